// File: rtl/obstacle_pkg.sv
// Shared obstacle type encoding used by the scheduler and the obstacle instances.
package obstacle_pkg;
  typedef enum logic [1:0] {
    NONE         = 2'd0,
    CACTUS_SMALL = 2'd1,
    CACTUS_LARGE = 2'd2,
    PTERODACTYL  = 2'd3
  } type_t;
endpackage

// File: rtl/obstacle_scheduler_if.sv
// Slot-side bus between the spawn scheduler (master) and the obstacle pool (slave).
interface obstacle_scheduler_if #(parameter int SLOTS = 3);
  logic                          [SLOTS-1:0]        slot_remove;
  logic signed                   [SLOTS-1:0][10:0]  slot_x_pos;
  logic                          [SLOTS-1:0][9:0]   slot_width;
  logic                          [SLOTS-1:0][10:0]  slot_gap;
  logic                          [SLOTS-1:0]        slot_start;
  obstacle_pkg::type_t           [SLOTS-1:0]        slot_typ;
  logic                          [SLOTS-1:0]        slot_busy;

  modport master (
    input  slot_remove, slot_x_pos, slot_width, slot_gap,
    output slot_start, slot_typ, slot_busy
  );
  modport slave (
    output slot_remove, slot_x_pos, slot_width, slot_gap,
    input  slot_start, slot_typ, slot_busy
  );
endinterface

// File: rtl/obstacle_scheduler.sv
// Per-frame obstacle spawn controller: tracks slot occupancy, enforces spawn gap,
// and picks an RNG-driven type under duplication and speed limits.
module obstacle_slot_ctl (
  input  logic                clk,
  input  logic                rst,
  input  logic                update,
  input  logic                start_now,
  input  logic                remove,
  input  obstacle_pkg::type_t cand,
  output logic                start_q,
  output logic                busy_q,
  output obstacle_pkg::type_t typ_q
);
  import obstacle_pkg::*;

  logic  start_d, busy_d;
  type_t typ_d;

  always_comb begin
    start_d = start_q;
    busy_d  = busy_q;
    typ_d   = typ_q;
    if (update) begin
      start_d = start_now;
      // A spawn on this frame overrides a remove left over from the old occupant
      busy_d  = start_now ? 1'b1 : (remove ? 1'b0 : busy_q);
      if (start_now) typ_d = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      typ_q   <= NONE;
    end else begin
      start_q <= start_d;
      busy_q  <= busy_d;
      typ_q   <= typ_d;
    end
  end
endmodule

module obstacle_scheduler #(
  parameter int SLOTS           = 3,
  parameter int MAX_DUP         = 2,
  parameter int CLEAR_FRAMES    = 180,
  parameter int PTERO_MIN_SPEED = 8704,
  parameter int GAME_WIDTH      = 640
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       update,
  input  logic                       running,
  input  logic                       crash,
  input  logic [5:0]                 timer,
  input  logic [14:0]                speed,
  input  logic [10:0]                rng_data,
  obstacle_scheduler_if.master       bus
);
  import obstacle_pkg::*;

  localparam int CW = (CLEAR_FRAMES > 0) ? $clog2(CLEAR_FRAMES + 1) : 1;
  localparam int DW = $clog2(MAX_DUP + 2);
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic [CW-1:0] clear_cnt_q, clear_cnt_d, clear_nxt;
  logic          run_d_q, run_d_d;
  type_t         last_type_q, last_type_d;
  logic [DW-1:0] dup_cnt_q, dup_cnt_d;
  logic [SW-1:0] tail_q, tail_d;

  logic [SLOTS-1:0] busy_q, start_q, start_now;
  type_t [SLOTS-1:0] typ_q;

  type_t               cand;
  logic [SW-1:0]       sel;
  logic                any_free, gap_ok, eligible, reject, spawn;
  logic signed [12:0]  tail_sum;
  logic [10:0]         tail_x;
  logic [9:0]          tail_w;
  logic [10:0]         tail_g;

  logic unused_timer;
  assign unused_timer = ^timer;

  always_comb begin
    clear_nxt = clear_cnt_q;
    if (running && !run_d_q)               clear_nxt = CW'(CLEAR_FRAMES);
    else if (running && clear_cnt_q != '0) clear_nxt = clear_cnt_q - 1'b1;

    any_free = ~&busy_q;
    tail_x   = bus.slot_x_pos[tail_q];
    tail_w   = bus.slot_width[tail_q];
    tail_g   = bus.slot_gap[tail_q];
    // x may be negative once an obstacle scrolls off the left edge
    tail_sum = $signed({{2{tail_x[10]}}, tail_x}) + $signed({3'b000, tail_w})
             + $signed({2'b00, tail_g});
    gap_ok   = (busy_q == '0) || !busy_q[tail_q] || (tail_sum < $signed(13'(GAME_WIDTH)));

    // The clear window uses this frame's post-decrement count so the first
    // spawn lands exactly CLEAR_FRAMES+1 updates after running rises
    eligible = running && !crash && run_d_q && (clear_nxt == '0) && any_free && gap_ok;

    cand   = type_t'(2'(rng_data % 11'd3) + 2'd1);
    reject = ((cand == last_type_q) && (dup_cnt_q >= DW'(MAX_DUP)))
          || ((cand == PTERODACTYL) && (speed < 15'(PTERO_MIN_SPEED)));

    sel = '0;
    for (int i = SLOTS - 1; i >= 0; i--)
      if (!busy_q[i]) sel = SW'(i);

    spawn = update && eligible && !reject;
    for (int i = 0; i < SLOTS; i++)
      start_now[i] = spawn && (sel == SW'(i));

    clear_cnt_d = update ? clear_nxt : clear_cnt_q;
    run_d_d     = update ? running   : run_d_q;
    last_type_d = last_type_q;
    dup_cnt_d   = dup_cnt_q;
    tail_d      = tail_q;
    if (spawn) begin
      last_type_d = cand;
      dup_cnt_d   = (cand == last_type_q) ? dup_cnt_q + 1'b1 : DW'(1);
      tail_d      = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clear_cnt_q <= '0;
      run_d_q     <= 1'b0;
      last_type_q <= NONE;
      dup_cnt_q   <= '0;
      tail_q      <= '0;
    end else begin
      clear_cnt_q <= clear_cnt_d;
      run_d_q     <= run_d_d;
      last_type_q <= last_type_d;
      dup_cnt_q   <= dup_cnt_d;
      tail_q      <= tail_d;
    end
  end

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    obstacle_slot_ctl u_slot (
      .clk       (clk),
      .rst       (rst),
      .update    (update),
      .start_now (start_now[i]),
      .remove    (bus.slot_remove[i]),
      .cand      (cand),
      .start_q   (start_q[i]),
      .busy_q    (busy_q[i]),
      .typ_q     (typ_q[i])
    );
  end

  assign bus.slot_start = start_q;
  assign bus.slot_busy  = busy_q;
  assign bus.slot_typ   = typ_q;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed table-driven bench for obstacle_scheduler with a few hand-written corner sequences.
module tb_obstacle_scheduler;
  logic        clk = 1'b0;
  logic        rst, update, running, crash;
  logic [5:0]  timer;
  logic [14:0] speed;
  logic [10:0] rng_data;

  obstacle_scheduler_if #(.SLOTS(3)) bus ();

  obstacle_scheduler #(
    .SLOTS(3), .MAX_DUP(2), .CLEAR_FRAMES(4), .PTERO_MIN_SPEED(8704), .GAME_WIDTH(640)
  ) dut (
    .clk(clk), .rst(rst), .update(update), .running(running), .crash(crash),
    .timer(timer), .speed(speed), .rng_data(rng_data), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic        crash;
    logic [10:0] rng;
    logic [14:0] spd;
    logic [2:0]  rem;
    logic [10:0] x0, x1, x2;
    logic [2:0]  e_start;
    logic [2:0]  e_busy;
    logic [5:0]  e_typ;
  } vec_t;

  vec_t tbl [19];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic r, input logic c, input int rng, input int spd,
                              input logic [2:0] rem, input int x0, input int x1, input int x2,
                              input logic [2:0] es, input logic [2:0] eb, input logic [5:0] et);
    vec_t v;
    v.run = r; v.crash = c; v.rng = 11'(rng); v.spd = 15'(spd); v.rem = rem;
    v.x0 = 11'(x0); v.x1 = 11'(x1); v.x2 = 11'(x2);
    v.e_start = es; v.e_busy = eb; v.e_typ = et;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_update();
    @(negedge clk) update = 1'b1;
    @(negedge clk) update = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] es, input logic [2:0] eb,
                            input logic [5:0] et);
    logic [5:0] t;
    t = bus.slot_typ;
    chk({tag, " start"}, 32'(bus.slot_start), 32'(es));
    chk({tag, " busy"},  32'(bus.slot_busy),  32'(eb));
    chk({tag, " typ"},   32'(t),              32'(et));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; update = 1'b0; running = 1'b0; crash = 1'b0; timer = '0;
    speed = 15'd10000; rng_data = '0;
    bus.slot_remove = '0;
    bus.slot_x_pos  = '0;
    bus.slot_width  = {10'd17, 10'd17, 10'd17};
    bus.slot_gap    = {11'd120, 11'd120, 11'd120};

    //            run crash rng spd    rem     x0   x1   x2   start   busy    typ {s2,s1,s0}
    tbl[0]  = mk(1, 0, 0, 10000, 3'b000, 0,   0,   0,   3'b000, 3'b000, 6'b00_00_00);
    tbl[1]  = mk(1, 0, 0, 10000, 3'b000, 0,   0,   0,   3'b000, 3'b000, 6'b00_00_00);
    tbl[2]  = mk(1, 0, 0, 10000, 3'b000, 0,   0,   0,   3'b000, 3'b000, 6'b00_00_00);
    tbl[3]  = mk(1, 0, 0, 10000, 3'b000, 0,   0,   0,   3'b000, 3'b000, 6'b00_00_00);
    tbl[4]  = mk(1, 0, 0, 10000, 3'b000, 0,   0,   0,   3'b001, 3'b001, 6'b00_00_01);
    tbl[5]  = mk(1, 0, 0, 10000, 3'b000, 600, 0,   0,   3'b000, 3'b001, 6'b00_00_01);
    tbl[6]  = mk(1, 0, 0, 10000, 3'b000, 502, 0,   0,   3'b010, 3'b011, 6'b00_01_01);
    tbl[7]  = mk(1, 0, 1, 10000, 3'b000, 0,   503, 0,   3'b000, 3'b011, 6'b00_01_01);
    tbl[8]  = mk(1, 0, 0, 10000, 3'b000, 0,   400, 0,   3'b000, 3'b011, 6'b00_01_01);
    tbl[9]  = mk(1, 0, 1, 10000, 3'b000, 0,   400, 0,   3'b100, 3'b111, 6'b10_01_01);
    tbl[10] = mk(1, 0, 1, 10000, 3'b000, 0,   0,   0,   3'b000, 3'b111, 6'b10_01_01);
    tbl[11] = mk(1, 0, 1, 10000, 3'b010, 0,   0,   0,   3'b000, 3'b101, 6'b10_01_01);
    tbl[12] = mk(1, 0, 2, 8703,  3'b000, 0,   0,   0,   3'b000, 3'b101, 6'b10_01_01);
    tbl[13] = mk(1, 0, 2, 8704,  3'b000, 0,   0,   0,   3'b010, 3'b111, 6'b10_11_01);
    tbl[14] = mk(1, 0, 0, 10000, 3'b001, 0,   0,   0,   3'b000, 3'b110, 6'b10_11_01);
    tbl[15] = mk(1, 1, 0, 10000, 3'b000, 0,   0,   0,   3'b000, 3'b110, 6'b10_11_01);
    tbl[16] = mk(1, 0, 1, 10000, 3'b000, 0,   0,   0,   3'b001, 3'b111, 6'b10_11_10);
    tbl[17] = mk(1, 1, 0, 10000, 3'b100, 0,   0,   0,   3'b000, 3'b011, 6'b10_11_10);
    tbl[18] = mk(1, 0, 0, 10000, 3'b100, 0,   0,   0,   3'b100, 3'b111, 6'b01_11_10);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outs("reset", 3'b000, 3'b000, 6'b0);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      running = tbl[i].run; crash = tbl[i].crash; rng_data = tbl[i].rng;
      speed = tbl[i].spd; bus.slot_remove = tbl[i].rem;
      bus.slot_x_pos = {tbl[i].x2, tbl[i].x1, tbl[i].x0};
      do_update();
      check_outs($sformatf("row%0d", i), tbl[i].e_start, tbl[i].e_busy, tbl[i].e_typ);
    end

    // Reset between updates must clear everything without waiting for a frame
    bus.slot_remove = '0; crash = 1'b0; rng_data = '0; bus.slot_x_pos = '0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_outs("midrst", 3'b000, 3'b000, 6'b0);

    // Internal state cleared too: running is seen as rising again and the clear window reloads
    for (int k = 1; k <= 4; k++) begin
      do_update();
      check_outs($sformatf("reclear%0d", k), 3'b000, 3'b000, 6'b0);
    end
    do_update();
    check_outs("respawn", 3'b001, 3'b001, 6'b00_00_01);

    // No update, no change
    repeat (3) @(negedge clk);
    check_outs("hold", 3'b001, 3'b001, 6'b00_00_01);

    running = 1'b0;
    do_update();
    check_outs("stopclr", 3'b000, 3'b001, 6'b00_00_01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
